div_40by8_seq: RTL and testbench

//  Sequential restoring divider: 40-bit dividend / 8-bit divisor -> 32-bit quotient, 8-bit remainder.

---
 rtl/div_40by8_seq_pkg.sv | 16 +
 rtl/div_40by8_seq_step.sv | 25 ++
 rtl/div_40by8_seq.sv | 136 +++++++++++++
 tb/tb_div_40by8_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/div_40by8_seq_pkg.sv
// Shared widths, FSM encoding and error constant for the 40/8 sequential divider.
package div_40by8_seq_pkg;

   localparam int NW = 40;
   localparam int DW = 8;
   localparam int QW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [QW-1:0] ERR_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_40by8_seq_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
module div_40by8_seq_step
   import div_40by8_seq_pkg::*;
(
   input  logic [DW-1:0] pr,
   input  logic          bit_in,
   input  logic [DW-1:0] divisor,
   output logic [DW:0]   pr_next,
   output logic          qbit
);

   logic [DW:0] trial;

   assign trial = {pr, bit_in};

   always_comb begin
      pr_next = trial;
      qbit    = 1'b0;
      if (trial >= {1'b0, divisor}) begin
         pr_next = trial - {1'b0, divisor};
         qbit    = 1'b1;
      end
   end

endmodule

// File: rtl/div_40by8_seq.sv
// Sequential restoring divider, 40-bit dividend by 8-bit divisor, one quotient bit per clock.
module div_40by8_seq
   import div_40by8_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [NW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] quotient,
   output logic [DW-1:0] remainder,
   output logic          dbz,
   output logic          ovf,
   output logic [1:0]    dbg_state
);

   // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
   // DONE); done is a one-cycle pulse and results are held until the next accept.

   state_e        state, state_n;
   logic [5:0]    cnt, cnt_n;
   logic [QW-1:0] sh, sh_n;
   logic [DW:0]   pr, pr_n;
   logic [DW-1:0] dvs, dvs_n;
   logic          busy_n, done_n, dbz_n, ovf_n;
   logic [QW-1:0] quot_n;
   logic [DW-1:0] rem_n;

   logic [DW:0]   step_pr;
   logic          step_q;
   logic          pr_msb_unused;

   // The partial remainder stays below the divisor, so its top bit is always 0.
   assign pr_msb_unused = pr[DW];
   assign dbg_state     = state;

   div_40by8_seq_step u_step (
      .pr      (pr[DW-1:0]),
      .bit_in  (sh[QW-1]),
      .divisor (dvs),
      .pr_next (step_pr),
      .qbit    (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sh        <= '0;
         pr        <= '0;
         dvs       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sh        <= sh_n;
         pr        <= pr_n;
         dvs       <= dvs_n;
         busy      <= busy_n;
         done      <= done_n;
         dbz       <= dbz_n;
         ovf       <= ovf_n;
         quotient  <= quot_n;
         remainder <= rem_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sh_n    = sh;
      pr_n    = pr;
      dvs_n   = dvs;
      busy_n  = busy;
      done_n  = 1'b0;
      dbz_n   = dbz;
      ovf_n   = ovf;
      quot_n  = quotient;
      rem_n   = remainder;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = CALC;
               cnt_n   = '0;
               sh_n    = dividend[QW-1:0];
               pr_n    = {1'b0, dividend[NW-1:QW]};
               dvs_n   = divisor;
               busy_n  = 1'b1;
               quot_n  = '0;
               rem_n   = '0;
               dbz_n   = (divisor == '0);
               ovf_n   = (divisor != '0) && (dividend[NW-1:QW] >= divisor);
            end else begin
               state_n = IDLE;
            end
         end

         CALC: begin
            // An error spends exactly one cycle here without stepping, so its
            // done lands one clock after accept.
            if (dbz || ovf) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               quot_n  = ERR_QUOT;
               rem_n   = dbz ? sh[DW-1:0] : '0;
            end else begin
               pr_n   = step_pr;
               sh_n   = {sh[QW-2:0], 1'b0};
               quot_n = {quotient[QW-2:0], step_q};
               cnt_n  = cnt + 6'd1;
               if (cnt == 6'd31) begin
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  rem_n   = step_pr[DW-1:0];
               end
            end
         end

         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div_40by8_seq.sv
// Directed-vector bench for div_40by8_seq with a queue-based scoreboard on done.
module tb_div_40by8_seq;

   localparam int W = 74;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [39:0] dividend;
   logic [7:0]  divisor;
   logic        busy, done, dbz, ovf;
   logic [31:0] quotient;
   logic [7:0]  remainder;
   logic [1:0]  dbg_state;

   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   div_40by8_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // driver: raise start (optionally on a fresh negedge), accept on next posedge, push expectation
   task automatic accept(input bit sync, input logic [39:0] n, input logic [7:0] d,
                         input logic [31:0] q, input logic [7:0] r, input logic z,
                         input logic o, input int lat);
      if (sync) @(negedge clk);
      start    = 1'b1;
      dividend = n;
      divisor  = d;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      exp_q.push_back({32'(cyc + lat), q, r, z, o});
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (!busy) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] e;
      rst      = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #1 rst = 1'b1;

      fork
         forever begin
            @(posedge clk);
            cyc++;
         end
         // scoreboard monitor
         forever begin
            @(negedge clk);
            if (!rst && done) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done: got done=1 want no pulse (t=%0t)", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("done_cycle", 32'(cyc), e[73:42]);
                  check("quotient", quotient, e[41:10]);
                  check("remainder", {24'b0, remainder}, {24'b0, e[9:2]});
                  check("dbz", 32'(dbz), {31'b0, e[1]});
                  check("ovf", 32'(ovf), {31'b0, e[0]});
                  check("busy_at_done", 32'(busy), 32'd0);
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quot", quotient, 32'd0);
      check("rst_rem", {24'b0, remainder}, 32'd0);
      check("rst_dbz", 32'(dbz), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;

      // 1000 / 7
      accept(1'b1, 40'd1000, 8'd7, 32'd142, 8'd6, 1'b0, 1'b0, 32);
      wait_done();
      // largest legal dividend for divisor 255
      accept(1'b1, 40'hFE_FFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 8'hFE, 1'b0, 1'b0, 32);
      wait_done();
      // multiplier round trip
      accept(1'b1, 40'h00_0003_0000, 8'd3, 32'h0001_0000, 8'd0, 1'b0, 1'b0, 32);
      wait_done();
      // divide by zero, then quotient overflow
      accept(1'b1, 40'h12_3456_7890, 8'd0, 32'hFFFF_FFFF, 8'h90, 1'b1, 1'b0, 1);
      wait_done();
      accept(1'b1, 40'h05_0000_0000, 8'd5, 32'hFFFF_FFFF, 8'd0, 1'b0, 1'b1, 1);
      wait_done();

      // start pulsed while busy is ignored; start during DONE is accepted
      accept(1'b1, 40'd100, 8'd9, 32'd11, 8'd1, 1'b0, 1'b0, 32);
      repeat (4) @(negedge clk);
      start    = 1'b1;
      dividend = 40'd50;
      divisor  = 8'd2;
      @(negedge clk);
      start = 1'b0;
      check("busy_ignore_start", 32'(busy), 32'd1);
      wait_done();
      accept(1'b0, 40'd200, 8'd7, 32'd28, 8'd4, 1'b0, 1'b0, 32);
      wait_done();

      // async reset mid-operation discards the result
      @(negedge clk);
      start    = 1'b1;
      dividend = 40'd1000;
      divisor  = 8'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_quot", quotient, 32'd0);
      check("mid_rst_rem", {24'b0, remainder}, 32'd0);
      check("mid_rst_flags", {30'b0, dbz, ovf}, 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      accept(1'b1, 40'd255, 8'd16, 32'd15, 8'd15, 1'b0, 1'b0, 32);
      wait_done();

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
